// File: rtl/nf_ifetch_pkg.sv
// ------------------------------------------------------------------
// nf_ifetch_pkg : shared types/constants for the instruction fetch unit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package nf_ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } nf_state_t;

  localparam logic [31:0] NF_NOP = 32'h0000_0013;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int nf_tmo_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nf_ifetch_unit.sv
// ------------------------------------------------------------------
// nf_ifetch_unit : req/ack instruction fetch with timeout and CPU strobe
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module nf_ifetch_unit
  import nf_ifetch_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] NOP_INSTR   = NF_NOP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr,
  output logic        cpu_en,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_err,
  output logic [31:0] instr_cnt
);

  localparam int          TW       = nf_tmo_width(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  nf_state_t     r_state;
  nf_state_t     w_next;
  logic [31:0]   r_instr;
  logic [31:0]   r_addr;
  logic          r_err;
  logic [31:0]   r_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo;

  assign w_tmo = (r_tmo_cnt == TMO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_REQ;
      ST_REQ:  if (imem_ack || w_tmo) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state   <= ST_IDLE;
      r_instr   <= NOP_INSTR;
      r_addr    <= 32'd0;
      r_err     <= 1'b0;
      r_cnt     <= 32'd0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (run) r_addr <= instr_addr;
        end
        ST_REQ: begin
          // Count on entry to EXEC so instr_cnt already includes the pulse it accompanies.
          if (imem_ack) begin
            r_instr   <= imem_rdata;
            r_tmo_cnt <= '0;
            r_cnt     <= r_cnt + 32'd1;
          end else if (w_tmo) begin
            r_instr   <= NOP_INSTR;
            r_err     <= 1'b1;
            r_tmo_cnt <= '0;
            r_cnt     <= r_cnt + 32'd1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so reset kills them asynchronously.
  assign imem_req  = (r_state == ST_REQ);
  assign cpu_en    = (r_state == ST_EXEC);
  assign instr     = r_instr;
  assign imem_addr = r_addr;
  assign fetch_err = r_err;
  assign instr_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nf_ifetch_unit.sv
// ------------------------------------------------------------------
// tb_nf_ifetch_unit : directed bench with instruction scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_nf_ifetch_unit;

  localparam int          TMO = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] instr_addr = 32'd0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [31:0] imem_addr;
  logic [31:0] instr_cnt;
  logic        cpu_en;
  logic        imem_req;
  logic        fetch_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_at = 1;
  int          req_n = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  nf_ifetch_unit #(.TIMEOUT_CYC(TMO), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .run        (run),
    .instr_addr (instr_addr),
    .instr      (instr),
    .cpu_en     (cpu_en),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .fetch_err  (fetch_err),
    .instr_cnt  (instr_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: acks on the ack_at-th consecutive request cycle (0 = never).
  always @(negedge clk) begin
    if (imem_req === 1'b1) req_n = req_n + 1;
    else req_n = 0;
    imem_ack   = (imem_req === 1'b1) && (ack_at != 0) && (req_n == ack_at);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  end

  // Scoreboard: every cpu_en pulse must present the next queued instruction.
  always @(negedge clk) begin
    if (resetn) begin
      exp_cnt = 32'd0;
    end else if (cpu_en === 1'b1) begin
      exp_cnt = exp_cnt + 32'd1;
      check("instr_cnt", instr_cnt, exp_cnt);
      if (exp_q.size() == 0) check("spurious_cpu_en", 32'(cpu_en), 32'd0);
      else check("instr", instr, exp_q.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] addr, input int ack_n, input int exp_reqc,
                       input bit tmo, input logic exp_err);
    int lat;
    int reqc;
    instr_addr = addr;
    ack_at     = ack_n;
    exp_q.push_back(tmo ? NOP : mem_word(addr));
    run = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (imem_req !== 1'b1 && lat < 20);
    check("req_latency", 32'(lat), 32'd1);
    run  = 1'b0;
    reqc = 0;
    while (imem_req === 1'b1 && reqc < 40) begin
      reqc++;
      check("imem_addr_held", imem_addr, addr);
      @(negedge clk);
    end
    check("req_cycles", 32'(reqc), 32'(exp_reqc));
    check("cpu_en_pulse", 32'(cpu_en), 32'd1);
    check("fetch_err", 32'(fetch_err), 32'(exp_err));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_req", 32'(imem_req), 32'd0);
      check("idle_cpu_en", 32'(cpu_en), 32'd0);
    end
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    check("rst_instr", instr, NOP);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_instr_cnt", instr_cnt, 32'd0);
    run = 1'b1;
    @(negedge clk);
    check("rst_blocks_req", 32'(imem_req), 32'd0);

    resetn = 1'b0;
    fetch(32'h0, 1, 1, 1'b0, 1'b0);
    check("instr_hold", instr, 32'h0050_0093);
    check("cnt_after_first", instr_cnt, 32'd1);

    fetch(32'h100, 6, 6, 1'b0, 1'b0);
    fetch(32'h200, 0, TMO, 1'b1, 1'b1);
    check("nop_hold", instr, NOP);
    fetch(32'h300, 1, 1, 1'b0, 1'b1);

    // Abort an outstanding request with an asynchronous reset.
    @(negedge clk);
    instr_addr = 32'h500;
    ack_at     = 0;
    run        = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (imem_req !== 1'b1 && lat < 20);
    check("abort_req_seen", 32'(imem_req), 32'd1);
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    check("abort_imem_req", 32'(imem_req), 32'd0);
    check("abort_cpu_en", 32'(cpu_en), 32'd0);
    check("abort_instr", instr, NOP);
    check("abort_imem_addr", imem_addr, 32'd0);
    check("abort_fetch_err", 32'(fetch_err), 32'd0);
    check("abort_instr_cnt", instr_cnt, 32'd0);
    run = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_cpu_en", 32'(cpu_en), 32'd0);
    end
    resetn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("halted_req", 32'(imem_req), 32'd0);
    end

    // Ack lands on the same cycle the timeout would fire.
    fetch(32'h400, TMO, TMO, 1'b0, 1'b0);
    check("cnt_after_abort", instr_cnt, 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
